// File: rtl/mux_arb_pkg.sv
// Shared types and the round-robin pick helper for the 4-requester mux arbiter.
package mux_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // Walk offsets high-to-low so the smallest offset from ptr wins.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                    input logic [SEL_W-1:0] ptr);
    pick_t            res;
    logic [SEL_W-1:0] k;
    res.found = 1'b0;
    res.idx   = ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = ptr + SEL_W'(i);
      if (req[k]) begin
        res.found = 1'b1;
        res.idx   = k;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_4_to_1_bus.sv
// DATA_W-wide combinational 4:1 mux steered by the arbiter's registered select.
module mux_4_to_1_bus
  import mux_arb_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [N_REQ*DATA_W-1:0] data_i,
  input  logic [SEL_W-1:0]        sel_i,
  output logic [DATA_W-1:0]       data_o
);

  always_comb begin
    case (sel_i)
      2'd0:    data_o = data_i[0*DATA_W +: DATA_W];
      2'd1:    data_o = data_i[1*DATA_W +: DATA_W];
      2'd2:    data_o = data_i[2*DATA_W +: DATA_W];
      2'd3:    data_o = data_i[3*DATA_W +: DATA_W];
      default: data_o = {DATA_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the 4:1 datapath mux select; grants bounded bursts
// and forwards the selected requester over a valid/ready handshake.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_REQ-1:0]        i_req_valid,
  input  logic [N_REQ*DATA_W-1:0] i_req_data,
  output logic [N_REQ-1:0]        o_req_ready,
  output logic                    o_valid,
  output logic [DATA_W-1:0]       o_data,
  input  logic                    i_ready,
  output logic [SEL_W-1:0]        o_sel,
  output logic                    o_busy
);

  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [3:0]       cnt_q, cnt_d;

  pick_t            pick_s;
  logic             busy_s;
  logic             sel_valid_s;
  logic             beat_s;
  logic [3:0]       cnt_inc_s;
  logic [DATA_W-1:0] mux_data_s;

  mux_4_to_1_bus #(.DATA_W(DATA_W)) u_mux (
    .data_i (i_req_data),
    .sel_i  (sel_q),
    .data_o (mux_data_s)
  );

  assign pick_s      = rr_pick(i_req_valid, ptr_q);
  assign busy_s      = (state_q == ST_GRANT);
  assign sel_valid_s = i_req_valid[sel_q];
  assign beat_s      = busy_s & sel_valid_s & i_ready;
  assign cnt_inc_s   = cnt_q + 4'd1;

  assign o_busy      = busy_s;
  assign o_sel       = sel_q;
  assign o_valid     = busy_s & sel_valid_s;
  assign o_data      = busy_s ? mux_data_s : {DATA_W{1'b0}};
  assign o_req_ready = (busy_s & i_ready) ? ({{(N_REQ-1){1'b0}}, 1'b1} << sel_q)
                                          : {N_REQ{1'b0}};

  // Next-state: grant on any request in IDLE; release on drop or full burst.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_s.found) begin
          sel_d   = pick_s.idx;
          cnt_d   = 4'd0;
          state_d = ST_GRANT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!sel_valid_s) begin
          state_d = ST_IDLE;
          ptr_d   = sel_q + 2'd1;
        end else if (beat_s) begin
          cnt_d = cnt_inc_s;
          if (cnt_inc_s == BURST_LIM) begin
            state_d = ST_IDLE;
            ptr_d   = sel_q + 2'd1;
          end else begin
            state_d = ST_GRANT;
          end
        end else begin
          state_d = ST_GRANT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Arbiter state, select, priority pointer and burst counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: a MAX_BURST=4 and a MAX_BURST=1 instance share stimulus.
module tb_mux_rr_arbiter;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] data;
  } beat_t;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic        ready;

  logic [3:0]  rr4, rr1;
  logic        valid4, valid1;
  logic [7:0]  data4, data1;
  logic [1:0]  sel4, sel1;
  logic        busy4, busy1;

  int    checks;
  int    failures;
  beat_t exp_q[$];

  mux_rr_arbiter #(.DATA_W(8), .MAX_BURST(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
    .o_req_ready(rr4), .o_valid(valid4), .o_data(data4), .i_ready(ready),
    .o_sel(sel4), .o_busy(busy4)
  );

  mux_rr_arbiter #(.DATA_W(8), .MAX_BURST(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
    .o_req_ready(rr1), .o_valid(valid1), .o_data(data1), .i_ready(ready),
    .o_sel(sel1), .o_busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beats(input int sel, input int n);
    beat_t e;
    for (int i = 0; i < n; i++) begin
      e.sel  = 2'(sel);
      e.data = 8'hA0 + 8'(sel);
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'b0000; ready = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (valid4 !== 1'b0 || rr4 !== 4'b0000 || sel4 !== 2'd0 || busy4 !== 1'b0 || data4 !== 8'h00) begin
      failures++;
      $display("FAIL reset_values: valid=%b ready=%b sel=%0d busy=%b data=%h, required all zero",
               valid4, rr4, sel4, busy4, data4);
    end
    rst = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (busy4 !== 1'b0 || valid4 !== 1'b0 || rr4 !== 4'b0000) begin
      failures++;
      $display("FAIL idle_after_reset: busy=%b valid=%b ready=%b, required 0/0/0", busy4, valid4, rr4);
    end
  endtask

  task automatic test_round_robin();
    beat_t e;
    int    n = 0;
    int    cyc = 0;
    bit    bubble = 1'b0;
    for (int g = 0; g < 5; g++) push_beats(g % 4, 4);
    tick();
    req_valid = 4'b1111; ready = 1'b1;
    while (exp_q.size() > 0 && cyc < 80) begin
      @(negedge clk);
      if (bubble) begin
        checks++;
        if (busy4 !== 1'b0) begin
          failures++;
          $display("FAIL rr_bubble: busy=%b after beat %0d, required 0", busy4, n);
        end
        bubble = 1'b0;
      end else if (valid4 && ready) begin
        e = exp_q.pop_front();
        checks++;
        if (sel4 !== e.sel || data4 !== e.data || rr4 !== (4'b0001 << e.sel)) begin
          failures++;
          $display("FAIL rr_beat%0d: sel=%0d data=%h ready=%b, required sel=%0d data=%h",
                   n, sel4, data4, rr4, e.sel, e.data);
        end
        n++;
        if (n % 4 == 0) bubble = 1'b1;
      end
      tick();
      cyc++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL rr_timeout: %0d beats missing, required 0", exp_q.size());
    end
    exp_q.delete();
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_drop();
    beat_t e;
    int    n = 0;
    int    cyc = 0;
    push_beats(2, 2);
    req_valid = 4'b0100;
    while (n < 2 && cyc < 20) begin
      @(negedge clk);
      if (valid4 && ready) begin
        e = exp_q.pop_front();
        checks++;
        if (sel4 !== e.sel || data4 !== e.data) begin
          failures++;
          $display("FAIL drop_beat%0d: sel=%0d data=%h, required sel=%0d data=%h", n, sel4, data4, e.sel, e.data);
        end
        n++;
      end
      tick();
      cyc++;
    end
    checks++;
    if (n != 2) begin
      failures++;
      $display("FAIL drop_timeout: beats=%0d, required 2", n);
    end
    exp_q.delete();
    req_valid = 4'b0000;
    @(negedge clk);
    checks++;
    if (busy4 !== 1'b1 || valid4 !== 1'b0 || rr4 !== 4'b0100) begin
      failures++;
      $display("FAIL drop_cycle: busy=%b valid=%b ready=%b, required 1/0/0100", busy4, valid4, rr4);
    end
    tick();
    @(negedge clk);
    checks++;
    if (busy4 !== 1'b0) begin
      failures++;
      $display("FAIL drop_release: busy=%b, required 0", busy4);
    end
    tick();
    req_valid = 4'b1010;
    tick();
    @(negedge clk);
    checks++;
    if (busy4 !== 1'b1 || sel4 !== 2'd3) begin
      failures++;
      $display("FAIL drop_next_grant: busy=%b sel=%0d, required busy=1 sel=3", busy4, sel4);
    end
    req_valid = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_backpressure();
    beat_t e;
    int    n = 0;
    int    cyc = 0;
    req_valid = 4'b0010; ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (valid4 !== 1'b1 || rr4 !== 4'b0000 || sel4 !== 2'd1 || busy4 !== 1'b1) begin
        failures++;
        $display("FAIL bp_stall%0d: valid=%b ready=%b sel=%0d busy=%b, required 1/0000/1/1",
                 i, valid4, rr4, sel4, busy4);
      end
      tick();
    end
    push_beats(1, 4);
    ready = 1'b1;
    while (exp_q.size() > 0 && cyc < 20) begin
      @(negedge clk);
      if (valid4 && ready) begin
        e = exp_q.pop_front();
        checks++;
        if (sel4 !== e.sel || data4 !== e.data || rr4 !== 4'b0010) begin
          failures++;
          $display("FAIL bp_beat%0d: sel=%0d data=%h ready=%b, required sel=1 data=%h", n, sel4, data4, rr4, e.data);
        end
        n++;
      end
      tick();
      cyc++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL bp_timeout: %0d beats missing, required 0", exp_q.size());
    end
    exp_q.delete();
    @(negedge clk);
    checks++;
    if (busy4 !== 1'b0) begin
      failures++;
      $display("FAIL bp_release: busy=%b after 4 beats, required 0", busy4);
    end
    req_valid = 4'b1111;
  endtask

  task automatic test_reset_mid();
    tick();
    @(negedge clk);
    checks++;
    if (busy4 !== 1'b1 || sel4 !== 2'd2) begin
      failures++;
      $display("FAIL pre_reset_grant: busy=%b sel=%0d, required busy=1 sel=2", busy4, sel4);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (valid4 !== 1'b0 || rr4 !== 4'b0000 || sel4 !== 2'd0 || busy4 !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: valid=%b ready=%b sel=%0d busy=%b, required all zero", valid4, rr4, sel4, busy4);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (busy4 !== 1'b1 || sel4 !== 2'd0 || data4 !== 8'hA0) begin
      failures++;
      $display("FAIL post_reset_grant: busy=%b sel=%0d data=%h, required 1/0/a0", busy4, sel4, data4);
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_burst1();
    beat_t e;
    int    n = 0;
    int    cyc = 0;
    int    prev = -1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      push_beats(1, 1);
      push_beats(3, 1);
    end
    req_valid = 4'b1010; ready = 1'b1;
    while (exp_q.size() > 0 && cyc < 30) begin
      @(negedge clk);
      if (valid1 && ready) begin
        e = exp_q.pop_front();
        checks++;
        if (sel1 !== e.sel || data1 !== e.data || (prev >= 0 && cyc - prev != 2)) begin
          failures++;
          $display("FAIL b1_beat%0d: sel=%0d data=%h gap=%0d, required sel=%0d data=%h gap=2",
                   n, sel1, data1, cyc - prev, e.sel, e.data);
        end
        prev = cyc;
        n++;
      end
      tick();
      cyc++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL b1_timeout: %0d beats missing, required 0", exp_q.size());
    end
    exp_q.delete();
    req_valid = 4'b0000;
  endtask

  task automatic test_mid_grant_request();
    beat_t e;
    int    n = 0;
    int    cyc = 0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push_beats(0, 4);
    push_beats(3, 1);
    req_valid = 4'b0001; ready = 1'b1;
    while (exp_q.size() > 0 && cyc < 30) begin
      @(negedge clk);
      if (valid4 && ready) begin
        e = exp_q.pop_front();
        checks++;
        if (sel4 !== e.sel || data4 !== e.data) begin
          failures++;
          $display("FAIL mid_beat%0d: sel=%0d data=%h, required sel=%0d data=%h", n, sel4, data4, e.sel, e.data);
        end
        n++;
        if (n == 1) req_valid = 4'b1001;
      end
      tick();
      cyc++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL mid_timeout: %0d beats missing, required 0", exp_q.size());
    end
    exp_q.delete();
    req_valid = 4'b0000;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    req_valid = 4'b0000;
    req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    ready     = 1'b1;
    test_reset();
    test_round_robin();
    test_drop();
    test_backpressure();
    test_reset_mid();
    test_burst1();
    test_mid_grant_request();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
